tone_scheduler: RTL and testbench

TONE_SCHEDULER -- requirements
Module: tone_scheduler

---
 rtl/tone_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_tone_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_scheduler.sv
// -----------------------------------------------------------------------------
// tone_scheduler
//
// Purpose:
//   Keeps a 4-deep last-note-priority stack of held keys and turns it into a
//   single note (half-period count) plus a gate for a square-wave tone
//   generator. Each key event is processed by a small FSM:
//     IDLE -> SCAN (4 cycles, one stack entry compared per cycle) -> COMMIT -> IDLE
//   Stack, held_count, note_out and gate all change on the COMMIT edge.
//   An event accepted at edge N is therefore visible after edge N+5.
//
// Optional feature:
//   TONE_SCHEDULER_ARP_EN - when defined, an arpeggiator steps note_out through
//   the held entries every ARP_TICKS cycles while two or more keys are held.
//   Without it, note_out always follows stack entry 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ev_valid     in   key event offered
//   ev_release   in   1 = key released, 0 = key pressed
//   ev_note      in   [25:0] half-period count of the key (0 = invalid note)
//   ev_ready     out  high only in IDLE; event taken when ev_valid & ev_ready
//   note_out     out  [25:0] half-period count for the tone generator
//   gate         out  1 while at least one key is held
//   note_changed out  one-cycle pulse after note_out or gate changes
//   held_count   out  [2:0] number of held notes, 0..4
// -----------------------------------------------------------------------------
module tone_scheduler #(
    parameter int unsigned ARP_TICKS = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ev_valid,
    input  logic        ev_release,
    input  logic [25:0] ev_note,
    output logic        ev_ready,
    output logic [25:0] note_out,
    output logic        gate,
    output logic        note_changed,
    output logic [2:0]  held_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [2:0] DEPTH = 3'd4;

    state_e       state_q, state_d;
    logic [1:0]   scan_idx_q, scan_idx_d;
    logic         found_q, found_d;
    logic [1:0]   match_idx_q, match_idx_d;
    logic         ev_rel_q, ev_rel_d;
    logic [25:0]  ev_note_q, ev_note_d;
    logic [25:0]  stack_q [4];
    logic [25:0]  stack_d [4];
    logic [2:0]   held_q, held_d;
    logic [25:0]  note_q, note_d;
    logic         changed_q, changed_d;
    logic [1:0]   note_sel;

    logic accept;
    logic commit;

    assign accept = ev_valid && (state_q == ST_IDLE);
    assign commit = (state_q == ST_COMMIT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (ev_valid) state_d = ST_SCAN;
            ST_SCAN:   if (scan_idx_q == 2'd3) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ev_ready = (state_q == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Event capture and scan
    // ------------------------------------------------------------------
    always_comb begin
        ev_rel_d    = ev_rel_q;
        ev_note_d   = ev_note_q;
        scan_idx_d  = scan_idx_q;
        found_d     = found_q;
        match_idx_d = match_idx_q;

        if (accept) begin
            ev_rel_d    = ev_release;
            ev_note_d   = ev_note;
            scan_idx_d  = 2'd0;
            found_d     = 1'b0;
            match_idx_d = 2'd0;
        end else if (state_q == ST_SCAN) begin
            scan_idx_d = scan_idx_q + 2'd1;
            // Scan runs upward, so the first hit is the lowest matching index.
            if (!found_q && ({1'b0, scan_idx_q} < held_q) &&
                (stack_q[scan_idx_q] == ev_note_q)) begin
                found_d     = 1'b1;
                match_idx_d = scan_idx_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stack update at COMMIT
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stack_d[i] = stack_q[i];
        end
        held_d = held_q;

        // A zero note is an invalid event: it runs the FSM but never
        // touches the stack.
        if (commit && (ev_note_q != 26'd0)) begin
            if (!ev_rel_q) begin
                if (found_q) begin
                    // Re-press of a held key: rotate it to the top.
                    for (int i = 1; i < 4; i++) begin
                        if (i <= int'(match_idx_q)) stack_d[i] = stack_q[i-1];
                    end
                    stack_d[0] = ev_note_q;
                end else begin
                    // New key: push; when full the oldest (entry 3) falls off.
                    for (int i = 1; i < 4; i++) begin
                        stack_d[i] = stack_q[i-1];
                    end
                    stack_d[0] = ev_note_q;
                    if (held_q < DEPTH) held_d = held_q + 3'd1;
                end
            end else if (found_q) begin
                // Release of a held key: close the gap from below.
                for (int i = 0; i < 3; i++) begin
                    if (i >= int'(match_idx_q)) stack_d[i] = stack_q[i+1];
                end
                stack_d[3] = 26'd0;
                held_d     = held_q - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Note selection (optional arpeggiator)
    // ------------------------------------------------------------------
`ifdef TONE_SCHEDULER_ARP_EN
    localparam int unsigned CNT_W = (ARP_TICKS > 1) ? $clog2(ARP_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARP_TICKS - 1);

    logic [CNT_W-1:0] arp_cnt_q, arp_cnt_d;
    logic [1:0]       arp_idx_q, arp_idx_d;

    always_comb begin
        arp_cnt_d = arp_cnt_q;
        arp_idx_d = arp_idx_q;
        // Every commit restarts the pattern from the newest note.
        if (commit || (held_q < 3'd2)) begin
            arp_cnt_d = '0;
            arp_idx_d = 2'd0;
        end else if (arp_cnt_q == CNT_LAST) begin
            arp_cnt_d = '0;
            arp_idx_d = (({1'b0, arp_idx_q} + 3'd1) >= held_q) ? 2'd0 : arp_idx_q + 2'd1;
        end else begin
            arp_cnt_d = arp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arp_cnt_q <= '0;
            arp_idx_q <= 2'd0;
        end else begin
            arp_cnt_q <= arp_cnt_d;
            arp_idx_q <= arp_idx_d;
        end
    end

    assign note_sel = arp_idx_d;
`else
    assign note_sel = 2'd0;
`endif

    always_comb begin
        // With no key held the last note is kept so the generator's release
        // tail stays on pitch.
        note_d    = (held_d != 3'd0) ? stack_d[note_sel] : note_q;
        changed_d = (note_d != note_q) || ((held_d != 3'd0) != (held_q != 3'd0));
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the 4-entry stack is reset along with the rest of the state so a
    // reset mid-event leaves no stale notes that a later scan could match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q  <= 2'd0;
            found_q     <= 1'b0;
            match_idx_q <= 2'd0;
            ev_rel_q    <= 1'b0;
            ev_note_q   <= 26'd0;
            for (int i = 0; i < 4; i++) begin
                stack_q[i] <= 26'd0;
            end
            held_q    <= 3'd0;
            note_q    <= 26'd0;
            changed_q <= 1'b0;
        end else begin
            scan_idx_q  <= scan_idx_d;
            found_q     <= found_d;
            match_idx_q <= match_idx_d;
            ev_rel_q    <= ev_rel_d;
            ev_note_q   <= ev_note_d;
            for (int i = 0; i < 4; i++) begin
                stack_q[i] <= stack_d[i];
            end
            held_q    <= held_d;
            note_q    <= note_d;
            changed_q <= changed_d;
        end
    end

    assign note_out     = note_q;
    assign gate         = (held_q != 3'd0);
    assign note_changed = changed_q;
    assign held_count   = held_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tone_scheduler
//
// Self-checking bench for tone_scheduler. A queue-based model of the
// last-note-priority stack predicts held_count, gate, note_out and the
// note_changed pulse for every event.
// -----------------------------------------------------------------------------
module tb_tone_scheduler;

    logic        clk;
    logic        rst_n;
    logic        ev_valid;
    logic        ev_release;
    logic [25:0] ev_note;
    logic        ev_ready;
    logic [25:0] note_out;
    logic        gate;
    logic        note_changed;
    logic [2:0]  held_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model: front of the queue is the most recent key.
    logic [25:0] m_stack [$];
    logic [25:0] m_note;

    tone_scheduler #(.ARP_TICKS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ev_valid     (ev_valid),
        .ev_release   (ev_release),
        .ev_note      (ev_note),
        .ev_ready     (ev_ready),
        .note_out     (note_out),
        .gate         (gate),
        .note_changed (note_changed),
        .held_count   (held_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_stack.delete();
        m_note = 26'd0;
    endfunction

    function automatic void model_apply(input logic rel, input logic [25:0] note);
        int idx = -1;
        if (note == 26'd0) return;
        foreach (m_stack[i]) if (idx < 0 && m_stack[i] == note) idx = i;
        if (!rel) begin
            if (idx >= 0) m_stack.delete(idx);
            m_stack.push_front(note);
            if (m_stack.size() > 4) void'(m_stack.pop_back());
        end else if (idx >= 0) begin
            m_stack.delete(idx);
        end
        if (m_stack.size() != 0) m_note = m_stack[0];
    endfunction

    // Offer one event, wait for the commit and compare all outputs.
    task automatic send_check(input logic rel, input logic [25:0] note, input string tag);
        int          n;
        logic [25:0] prev_note;
        logic        prev_gate;
        logic        exp_chg;
        logic [2:0]  exp_held;
        @(negedge clk);
        n = 0;
        while (!ev_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ev_ready) begin
            errors++;
            $display("FAIL %s: ev_ready timeout, ev_ready=%b required 1", tag, ev_ready);
            return;
        end
        ev_valid   = 1'b1;
        ev_release = rel;
        ev_note    = note;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        prev_note = m_note;
        prev_gate = (m_stack.size() != 0);
        model_apply(rel, note);
        exp_chg  = (prev_note != m_note) || (prev_gate != (m_stack.size() != 0));
        exp_held = 3'(m_stack.size());
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (held_count !== exp_held) begin
            errors++;
            $display("FAIL %s held_count: got %0d required %0d", tag, held_count, exp_held);
        end
        checks++;
        if (gate !== (exp_held != 3'd0)) begin
            errors++;
            $display("FAIL %s gate: got %b required %b", tag, gate, exp_held != 3'd0);
        end
        checks++;
        if (note_out !== m_note) begin
            errors++;
            $display("FAIL %s note_out: got %h required %h", tag, note_out, m_note);
        end
        checks++;
        if (note_changed !== exp_chg) begin
            errors++;
            $display("FAIL %s note_changed: got %b required %b", tag, note_changed, exp_chg);
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ev_ready after commit: got %b required 1", tag, ev_ready);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ev_valid   = 1'b0;
        ev_release = 1'b0;
        ev_note    = 26'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ev_ready, gate, note_changed, held_count, note_out} !== {1'b1, 1'b0, 1'b0, 3'd0, 26'd0}) begin
            errors++;
            $display("FAIL reset_values: got ready=%b gate=%b chg=%b held=%0d note=%h required 1 0 0 0 0",
                     ev_ready, gate, note_changed, held_count, note_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_note();
        send_check(1'b0, 26'h017BB, "single_press");
        @(posedge clk);
        #1;
        checks++;
        if (note_changed !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: note_changed=%b required 0", note_changed);
        end
        send_check(1'b1, 26'h017BB, "single_release");
    endtask

    task automatic test_priority();
        send_check(1'b0, 26'd100, "prio_press_a");
        send_check(1'b0, 26'd200, "prio_press_b");
        send_check(1'b1, 26'd200, "prio_release_b");
        send_check(1'b1, 26'd100, "prio_release_a");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            send_check(1'b0, 26'(10 * i), $sformatf("ovf_press_%0d", 10 * i));
        end
        send_check(1'b1, 26'd10, "ovf_release_dropped");
        send_check(1'b0, 26'd0, "ovf_zero_note");
        send_check(1'b0, 26'd30, "ovf_repress_30");
        for (int i = 2; i <= 5; i++) begin
            send_check(1'b1, 26'(10 * i), $sformatf("ovf_release_%0d", 10 * i));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        ev_valid   = 1'b1;
        ev_release = 1'b0;
        ev_note    = 26'd300;
        @(posedge clk);
        #1;
        model_apply(1'b0, 26'd300);
        ev_note = 26'd400;
        @(negedge clk);
        n = 0;
        while (!ev_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL b2b_ready_low: got %0d cycles required 5", n);
        end
        checks++;
        if (note_out !== m_note || held_count !== 3'(m_stack.size())) begin
            errors++;
            $display("FAIL b2b_first_event: got note=%h held=%0d required note=%h held=%0d",
                     note_out, held_count, m_note, m_stack.size());
        end
        @(posedge clk);
        #1 ev_valid = 1'b0;
        model_apply(1'b0, 26'd400);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (note_out !== m_note || held_count !== 3'(m_stack.size())) begin
            errors++;
            $display("FAIL b2b_second_event: got note=%h held=%0d required note=%h held=%0d",
                     note_out, held_count, m_note, m_stack.size());
        end
        send_check(1'b1, 26'd400, "b2b_release_400");
        send_check(1'b1, 26'd300, "b2b_release_300");
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        ev_valid   = 1'b1;
        ev_release = 1'b0;
        ev_note    = 26'h00ABC;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ev_ready, gate, note_changed, held_count, note_out} !== {1'b1, 1'b0, 1'b0, 3'd0, 26'd0}) begin
            errors++;
            $display("FAIL midscan_reset: got ready=%b gate=%b chg=%b held=%0d note=%h required 1 0 0 0 0",
                     ev_ready, gate, note_changed, held_count, note_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (held_count !== 3'd0 || gate !== 1'b0) begin
            errors++;
            $display("FAIL midscan_discard: got held=%0d gate=%b required 0 0", held_count, gate);
        end
        send_check(1'b1, 26'h00ABC, "midscan_release_unheld");
        send_check(1'b0, 26'h00055, "midscan_fresh_press");
        send_check(1'b1, 26'h00055, "midscan_fresh_release");
    endtask

    task automatic test_random();
        logic        rel;
        logic [25:0] note;
        for (int i = 0; i < 40; i++) begin
            rel  = 1'($urandom_range(0, 1));
            note = ($urandom_range(0, 9) == 0) ? 26'd0 : 26'(1000 + $urandom_range(0, 6));
            send_check(rel, note, $sformatf("rand_%0d", i));
        end
    endtask

`ifdef TONE_SCHEDULER_ARP_EN
    task automatic test_arpeggio();
        logic [25:0] exp_note;
        test_reset();
        send_check(1'b0, 26'd100, "arp_press_100");
        send_check(1'b0, 26'd200, "arp_press_200");
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp_note = (((k / 4) % 2) == 0) ? 26'd200 : 26'd100;
            checks++;
            if (note_out !== exp_note || note_changed !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL arp_step_%0d: got note=%0d chg=%b required note=%0d chg=%b",
                         k, note_out, note_changed, exp_note, (k % 4) == 0);
            end
        end
        send_check(1'b0, 26'd300, "arp_restart");
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (note_out !== 26'd200) begin
            errors++;
            $display("FAIL arp_after_restart: got %0d required 200", note_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_note();
        test_priority();
        test_overflow();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
`ifdef TONE_SCHEDULER_ARP_EN
        test_arpeggio();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
